xor_unit_arbiter: RTL and testbench

Shares one registered XOR compute unit (result = A ^ B) between NREQ requesters. It arbitrates round-robin, latches the winner's operands, computes, and returns the result with the requester ID over a valid/ready response port. It sits between the operand-producing clients and the downstream result consumer. It replaces per-client combinational XOR logic with one clocked, fully specified resource.

---
 rtl/xor_unit_arbiter.sv | 147 ++++++++++++++
 tb/tb_xor_unit_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/xor_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : xor_unit_arbiter
// Description : One registered XOR unit (A ^ B) shared round-robin between
//               NREQ requesters. A winner is chosen in IDLE and its operands
//               are latched. The XOR is registered in BUSY. The result and the
//               requester ID are presented in RESP until the consumer accepts.
// Ports       : clk        - rising-edge clock
//               rst_n      - synchronous active-low reset
//               req        - per-requester request level [NREQ]
//               a_in/b_in  - packed operands, requester i at [i*W +: W]
//               gnt        - one-hot, one-cycle acceptance pulse
//               rsp_valid  - result available (valid/ready with rsp_ready)
//               rsp_ready  - consumer accepts the result
//               rsp_id     - index of the requester owning rsp_data
//               rsp_data   - XOR result
//               busy       - high whenever the unit is not idle
//               op_count   - completed responses, saturating at 16'hFFFF
// Revision    : 1.0 - initial release
// ============================================================================
module xor_unit_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              busy,
  output logic [15:0]       op_count
);

  localparam logic [1:0]   c_st_idle = 2'd0;
  localparam logic [1:0]   c_st_busy = 2'd1;
  localparam logic [1:0]   c_st_resp = 2'd2;
  localparam logic [IDW:0] c_nreq    = (IDW+1)'(NREQ);

  logic [1:0]      r_state;
  logic [1:0]      w_state_next;
  logic [IDW-1:0]  r_ptr;
  logic [NREQ-1:0] r_gnt;
  logic [W-1:0]    r_a_lat;
  logic [W-1:0]    r_b_lat;
  logic [IDW-1:0]  r_id;
  logic [W-1:0]    r_result;
  logic [15:0]     r_op_count;

  logic [W-1:0]    w_a [NREQ];
  logic [W-1:0]    w_b [NREQ];
  logic [NREQ-1:0] w_rot;
  logic [IDW-1:0]  w_off;
  logic [IDW:0]    w_win_sum;
  logic [IDW-1:0]  w_win;
  logic [IDW:0]    w_nxt_sum;
  logic [IDW-1:0]  w_ptr_next;
  logic            w_any;

  // Unpack the flat operand buses into per-requester words.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_a[i] = a_in[i*W +: W];
    assign w_b[i] = b_in[i*W +: W];
  end

  // Round-robin search: rotate req so that bit 0 is requester ptr, take the
  // lowest set bit as an offset from ptr, then map the offset back modulo
  // NREQ. The doubled vector makes the rotation work for any NREQ.
  always_comb begin
    w_rot = NREQ'({req, req} >> r_ptr);
    w_any = |req;
    w_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IDW'(k);
    end
    w_win_sum  = {1'b0, r_ptr} + {1'b0, w_off};
    w_win      = IDW'((w_win_sum >= c_nreq) ? (w_win_sum - c_nreq) : w_win_sum);
    w_nxt_sum  = {1'b0, w_win} + {{IDW{1'b0}}, 1'b1};
    w_ptr_next = (w_nxt_sum == c_nreq) ? '0 : w_nxt_sum[IDW-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (w_any)     w_state_next = c_st_busy;
      c_st_busy:                w_state_next = c_st_resp;
      c_st_resp: if (rsp_ready) w_state_next = c_st_idle;
      default:                  w_state_next = c_st_idle;
    endcase
  end

  // Datapath, grant pulse, pointer and counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_a_lat    <= '0;
      r_b_lat    <= '0;
      r_id       <= '0;
      r_result   <= '0;
      r_op_count <= '0;
    end else begin
      r_gnt <= '0;
      case (r_state)
        c_st_idle: begin
          if (w_any) begin
            r_gnt   <= NREQ'(1) << w_win;
            r_a_lat <= w_a[w_win];
            r_b_lat <= w_b[w_win];
            r_id    <= w_win;
            r_ptr   <= w_ptr_next;
          end
        end
        c_st_busy: r_result <= r_a_lat ^ r_b_lat;
        c_st_resp: begin
          if (rsp_ready && (r_op_count != 16'hFFFF))
            r_op_count <= r_op_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy      = (r_state != c_st_idle);
    rsp_valid = (r_state == c_st_resp);
    gnt       = r_gnt;
    rsp_id    = r_id;
    rsp_data  = r_result;
    op_count  = r_op_count;
  end

endmodule
`default_nettype wire

// File: tb/tb_xor_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_xor_unit_arbiter
// Description : Directed self-checking bench for xor_unit_arbiter (NREQ=4,
//               W=8) with hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_unit_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        busy;
  logic [15:0] op_count;

  int n_checks = 0;
  int n_errors = 0;

  xor_unit_arbiter #(.NREQ(4), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 4'b0000;
    a_in      = '0;
    b_in      = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_gnt", gnt, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", op_count, 0);

    // Withdrawn request: high only between edges
    req = 4'b0100;
    #3;
    req = 4'b0000;
    tick();
    chk("wd_gnt", gnt, 0);
    chk("wd_busy", busy, 0);
    tick();
    tick();
    chk("wd_valid", rsp_valid, 0);
    chk("wd_count", op_count, 0);

    // Single request from requester 1
    req       = 4'b0010;
    a_in      = 32'h0000_A500;
    b_in      = 32'h0000_3C00;
    rsp_ready = 1'b1;
    tick();
    chk("s_gnt", gnt, 4'b0010);
    chk("s_busy", busy, 1);
    chk("s_valid0", rsp_valid, 0);
    req = 4'b0000;
    tick();
    chk("s_gnt_off", gnt, 0);
    chk("s_valid", rsp_valid, 1);
    chk("s_id", rsp_id, 1);
    chk("s_data", rsp_data, 8'h99);
    tick();
    chk("s_valid_off", rsp_valid, 0);
    chk("s_idle", busy, 0);
    chk("s_count", op_count, 1);

    // Reset to bring the pointer back to 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("r2_count", op_count, 0);

    // Full contention: grants 0,1,2,3,0 spaced 3 cycles apart
    req  = 4'b1111;
    a_in = 32'h1312_1110;
    b_in = 32'h0101_0101;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("fc_gnt", gnt, 32'd1 << (g % 4));
      tick();
      chk("fc_valid", rsp_valid, 1);
      chk("fc_id", rsp_id, g % 4);
      chk("fc_data", rsp_data, (32'h10 + (g % 4)) ^ 32'h01);
      tick();
      chk("fc_valid_off", rsp_valid, 0);
      chk("fc_count", op_count, g + 1);
    end
    req = 4'b0000;

    // Back-pressure: pointer is 1, requester 2 alone wins
    req       = 4'b0100;
    a_in      = 32'h13F0_1110;
    b_in      = 32'h010F_0101;
    rsp_ready = 1'b0;
    tick();
    chk("bp_gnt", gnt, 4'b0100);
    req = 4'b1111;
    tick();
    chk("bp_valid", rsp_valid, 1);
    chk("bp_data", rsp_data, 8'hFF);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_id", rsp_id, 2);
      chk("bp_hold_data", rsp_data, 8'hFF);
      chk("bp_hold_gnt", gnt, 0);
      chk("bp_hold_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_done_valid", rsp_valid, 0);
    chk("bp_done_busy", busy, 0);
    chk("bp_done_count", op_count, 6);

    // Pending requesters now arbitrate from ptr=3
    tick();
    chk("wr_gnt3", gnt, 4'b1000);
    req = 4'b0000;
    tick();
    chk("wr_id3", rsp_id, 3);
    chk("wr_data3", rsp_data, 8'h12);
    tick();
    chk("wr_count3", op_count, 7);

    // Wrap-around: ptr=0, so 4'b1001 grants 0, then 3
    req = 4'b1001;
    tick();
    chk("wr_gnt0", gnt, 4'b0001);
    req = 4'b0000;
    tick();
    chk("wr_data0", rsp_data, 8'h11);
    tick();
    chk("wr_count0", op_count, 8);
    req = 4'b1001;
    tick();
    chk("wr_gnt3b", gnt, 4'b1000);
    req       = 4'b0000;
    rsp_ready = 1'b0;
    tick();
    chk("mr_valid_pre", rsp_valid, 1);

    // Reset while in RESP: response discarded
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_gnt", gnt, 0);
    chk("mr_valid", rsp_valid, 0);
    chk("mr_id", rsp_id, 0);
    chk("mr_data", rsp_data, 0);
    chk("mr_busy", busy, 0);
    chk("mr_count", op_count, 0);

    // Fresh request after reset: ptr=0 priority picks requester 1
    req       = 4'b1010;
    rsp_ready = 1'b1;
    tick();
    chk("fr_gnt", gnt, 4'b0010);
    req = 4'b0000;
    tick();
    chk("fr_id", rsp_id, 1);
    chk("fr_data", rsp_data, 8'h10);
    tick();
    chk("fr_count", op_count, 1);
    chk("fr_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
